// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory model that answers a simple CPU request strobe.
// A request is accepted in IDLE. It then spends WAIT_CYCLES wait states in
// WAIT and completes with a one-cycle MemReady pulse in DONE.
//   - Reads load ReadData when DONE is entered, and ReadData holds that value
//     until the next completed read.
//   - Writes commit to storage on the edge that leaves DONE.
//   - Storage is never cleared by reset.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : wait states inserted before each response (0..15)
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   MemReq    : request strobe, sampled only in IDLE
//   MemWE     : 1 = write, 0 = read, sampled with MemReq
//   Adr       : byte address; the word index is Adr[log2(DEPTH_WORDS)+1:2]
//   WriteData : write data, sampled with MemReq
//   ReadData  : result of the last completed read
//   MemReady  : one-cycle completion pulse
//   MemErr    : misaligned-request flag, alongside MemReady
//               (present only when MEM_ALIGN_CHECK_EN is defined)
//
// Build option
//   MEM_ALIGN_CHECK_EN : when defined, a request with Adr[1:0] != 0 completes
//                        with normal timing and raises MemErr. Such a request
//                        neither writes storage nor updates ReadData. When the
//                        macro is undefined, Adr[1:0] is ignored and the MemErr
//                        port is absent.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWE,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        MemErr
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        rdata_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               reqMisaligned;
    logic               loadRead;
    logic               commitWrite;
    logic               unusedAdrBits;

`ifdef MEM_ALIGN_CHECK_EN
    assign reqMisaligned = (Adr[1:0] != 2'b00);
`else
    assign reqMisaligned = 1'b0;
`endif

    // Address bits above the word index alias. The byte-offset bits are only
    // looked at when alignment checking is built in.
    assign unusedAdrBits = ^{Adr[31:IDX_W+2], Adr[1:0]};

    // Next-state logic. The request fields are captured in IDLE only.
    // The counter leaves WAIT on the edge where it reads 1, so a request
    // spends exactly WAIT_CYCLES cycles in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (MemReq) begin
                    we_d       = MemWE;
                    idx_d      = Adr[IDX_W+1:2];
                    wdata_d    = WriteData;
                    misalign_d = reqMisaligned;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A read picks up its word on the edge that enters DONE. The index is
    // taken from idx_d so that the WAIT_CYCLES=0 path, which goes straight
    // from IDLE to DONE, reads the address being accepted.
    assign loadRead    = (state_d == DONE) && (state_q != DONE) && !we_d && !misalign_d;
    assign commitWrite = (state_q == DONE) && we_q && !misalign_q;

    // Control and result registers. Reset abandons any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            if (loadRead) begin
                rdata_q <= mem_q[idx_d];
            end
        end
    end

    // Storage has no reset. Reset is still sampled here, so a write that is
    // in DONE when reset arrives does not commit.
    always_ff @(posedge clk) begin
        if (commitWrite && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = (state_q == DONE);
`ifdef MEM_ALIGN_CHECK_EN
    assign MemErr   = (state_q == DONE) && misalign_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Scoreboard bench for mem_responder with WAIT_CYCLES=2 and DEPTH_WORDS=64.
// Each issued request pushes its expected response, computed from a plain
// word-array model, into a queue. A separate monitor pops an entry on every
// MemReady pulse and compares the response latency, ReadData and (when
// built in) MemErr.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int W  = 2;
    localparam int D  = 64;
    localparam int AW = $clog2(D);

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MemErr;
`endif

    typedef struct {
        int          acceptCycle;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          pulseCount = 0;
    logic [31:0] modelMem [D];
    int          validIdx[$];
    logic [31:0] modelRead = 32'h0;

    mem_responder #(
        .DEPTH_WORDS(D),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemReq   (MemReq),
        .MemWE    (MemWE),
        .Adr      (Adr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .MemReady (MemReady)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .MemErr   (MemErr)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp acceptance and completion
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cycleCount);
        end
    endtask

    // Monitor. A pulse seen at a falling edge is sampled by the next rising
    // edge, so its latency is that edge's index minus the accepting edge's index.
    always @(negedge clk) begin
        if (!reset && MemReady) begin
            pulseCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedReady actual=1 required=0 (cycle %0d)", cycleCount);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("latency", 32'(cycleCount + 1 - e.acceptCycle), 32'(W + 1));
                checkOutput("readData", ReadData, e.data);
`ifdef MEM_ALIGN_CHECK_EN
                checkOutput("memErr", {31'd0, MemErr}, {31'd0, e.err});
`endif
            end
        end
`ifdef MEM_ALIGN_CHECK_EN
        if (!MemReady) begin
            checkOutput("memErrIdle", {31'd0, MemErr}, 32'd0);
        end
`endif
    end

    // Work out the expected response for one request and update the model.
    function automatic exp_t predict(input bit we, input logic [31:0] adr, input int acc);
        exp_t e;
        int   idx;
        idx = int'(adr[AW+1:2]);
        e.acceptCycle = acc;
`ifdef MEM_ALIGN_CHECK_EN
        e.err = (adr[1:0] != 2'b00);
`else
        e.err = 1'b0;
`endif
        if (we) begin
            e.data = modelRead;
        end else begin
            if (!e.err) modelRead = modelMem[idx];
            e.data = modelRead;
        end
        return e;
    endfunction

    function automatic void modelWrite(input logic [31:0] adr, input logic [31:0] wd);
        int idx;
        bit found;
        idx = int'(adr[AW+1:2]);
`ifdef MEM_ALIGN_CHECK_EN
        if (adr[1:0] != 2'b00) return;
`endif
        modelMem[idx] = wd;
        found = 0;
        foreach (validIdx[i]) if (validIdx[i] == idx) found = 1;
        if (!found) validIdx.push_back(idx);
    endfunction

    // Issue one request while the DUT is idle, starting just after a falling
    // edge. Returns once the next request may be accepted.
    task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] wd);
        exp_t e;
        e = predict(we, adr, cycleCount + 1);
        if (we) modelWrite(adr, wd);
        expQ.push_back(e);
        MemReq    = 1'b1;
        MemWE     = we;
        Adr       = adr;
        WriteData = wd;
        @(negedge clk);
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        Adr       = $urandom;
        WriteData = $urandom;
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        int startPulses;
        int firstAcc;

        reset     = 1'b1;
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        Adr       = 32'h0;
        WriteData = 32'h0;

        // Reset held, then idle for 10 cycles
        repeat (3) begin
            @(negedge clk);
            checkOutput("resetReady", {31'd0, MemReady}, 32'd0);
            checkOutput("resetReadData", ReadData, 32'h0);
        end
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("idleReady", {31'd0, MemReady}, 32'd0);
            checkOutput("idleReadData", ReadData, 32'h0);
        end

        // Write and read back, then aliased access
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 32'h04, 32'h12345678);
        applyStimulus(1'b0, 32'h104, 32'h0);

        // MemReq held high for 8 cycles: accepts at +1 and +5
        startPulses = pulseCount;
        firstAcc    = cycleCount + 1;
        expQ.push_back(predict(1'b0, 32'h10, firstAcc));
        expQ.push_back(predict(1'b0, 32'h10, firstAcc + W + 2));
        MemReq = 1'b1;
        MemWE  = 1'b0;
        Adr    = 32'h10;
        repeat (8) @(negedge clk);
        MemReq = 1'b0;
        repeat (W + 3) @(negedge clk);
        checkOutput("heldReqAccepts", 32'(pulseCount - startPulses), 32'd2);

        // Reset during WAIT aborts a write
        applyStimulus(1'b1, 32'h20, 32'h0);
        startPulses = pulseCount;
        MemReq    = 1'b1;
        MemWE     = 1'b1;
        Adr       = 32'h20;
        WriteData = 32'hCAFEF00D;
        @(negedge clk);
        MemReq = 1'b0;
        reset  = 1'b1;
        modelRead = 32'h0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abortReady", {31'd0, MemReady}, 32'd0);
            checkOutput("abortReadData", ReadData, 32'h0);
        end
        reset = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0);
        checkOutput("abortPulses", 32'(pulseCount - startPulses), 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned write reports an error and leaves storage untouched
        applyStimulus(1'b1, 32'h11, 32'h55AA55AA);
        applyStimulus(1'b0, 32'h10, 32'h0);
`endif

        // Randomized traffic; reads target only words that have been written
        for (int n = 0; n < 60; n++) begin
            bit          we;
            int          idx;
            logic [31:0] adr;
            we = ($urandom_range(0, 1) == 1);
            if (we) idx = int'($urandom_range(0, D - 1));
            else    idx = validIdx[$urandom_range(0, validIdx.size() - 1)];
            adr = $urandom;
            adr[AW+1:2] = AW'(idx);
`ifdef MEM_ALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) adr[1:0] = 2'b00;
`endif
            applyStimulus(we, adr, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain, with a bounded wait for outstanding responses
        for (int t = 0; t < 20 && expQ.size() != 0; t++) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0 responses outstanding", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have one parameter per line below (name, default, meaning):
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, >=4.
- WAIT_CYCLES, 2, wait states inserted before each response; 0..15.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- MemReq, in, 1, CPU request strobe; sampled only in IDLE.
- MemWE, in, 1, 1 = write, 0 = read; sampled with MemReq.
- Adr, in, 32, byte address; sampled with MemReq.
- WriteData, in, 32, write data; sampled with MemReq.
- ReadData, out, 32, read result; valid while MemReady=1, then held.
- MemReady, out, 1, one-cycle completion pulse.
- MemErr, out, 1, error flag, present only per REQ-017.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-004 In IDLE, MemReq=1 at a rising edge SHALL latch MemWE, Adr and WriteData, then:
- go to WAIT with the counter loaded to WAIT_CYCLES, or
- go directly to DONE when WAIT_CYCLES=0.
REQ-005 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to DONE on the edge where the counter equals 1.
REQ-006 In DONE, MemReady SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-007 Latency: MemReady SHALL assert WAIT_CYCLES+1 cycles after the accepting edge.
- Minimum request-to-request spacing SHALL be WAIT_CYCLES+2 cycles.
REQ-008 MemReq, MemWE, Adr and WriteData SHALL be ignored in WAIT and DONE.
- MemReq held high through DONE SHALL be accepted at the first IDLE edge that follows.
REQ-009 The word index SHALL be latched Adr[log2(DEPTH_WORDS)+1:2].
- Higher address bits SHALL be ignored, so addresses alias modulo DEPTH_WORDS*4.
REQ-010 A write SHALL commit to storage at the edge leaving DONE; ReadData SHALL be unchanged by a write.
REQ-011 A read SHALL load ReadData with the addressed word at the edge entering DONE.
- ReadData SHALL hold that value until the next completed read.
REQ-012 A read following a completed write to the same word SHALL return the new data.
REQ-013 Storage contents SHALL be undefined until first written; reset SHALL NOT clear storage.

Reset
REQ-014 While reset=1, the block SHALL hold: FSM=IDLE, counter=0, MemReady=0, ReadData=32'h0, MemErr=0.
REQ-015 Reset asserted mid-operation (WAIT or DONE) SHALL abort the request:
- no write commits;
- no MemReady pulse is produced.
REQ-016 The first request SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-017 Macro MEM_ALIGN_CHECK_EN SHALL select alignment checking.
- Defined: the MemErr port exists. A request with Adr[1:0]!=0 completes with normal timing and MemReady=1 plus MemErr=1 in the same cycle. No write commits, and ReadData is unchanged. MemErr is 0 at all other times.
- Undefined: the MemErr port is absent, and Adr[1:0] is ignored.

Verification
REQ-018 The bench SHALL cover these directed scenarios with WAIT_CYCLES=2, DEPTH_WORDS=64:
- Reset then idle: MemReady=0 and ReadData=0 for 10 cycles.
- Write 32'hDEADBEEF to Adr 0x10, then read 0x10: each MemReady pulse occurs 3 cycles after acceptance, and the read returns 32'hDEADBEEF.
- Write 32'h12345678 to 0x04, then read 0x104: the read returns 32'h12345678 (aliasing).
- MemReq held high for 8 cycles with a read of 0x10: exactly 2 accepts, the second accepted 4 cycles after the first.
- Reset asserted during WAIT of a write of 32'hCAFEF00D to 0x20, then read 0x20 after the value 32'h0 was written there first: returns 32'h0 and no MemReady pulse occurs during the aborted request.
- With MEM_ALIGN_CHECK_EN: write to Adr 0x11 gives MemReady=1 with MemErr=1 after 3 cycles; a following read of 0x10 returns the prior contents.
